// File: rtl/dff_bank_arbiter.sv
// Shared WIDTH-bit register bank (q/qbar) written by one of N requesters at a time.
// Round-robin pick in IDLE, write in LOAD, one-cycle ack in ACK.
module dff_bank_arbiter #(
    parameter int unsigned       N       = 4,
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   data,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qbar,
    output logic                 busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     win_q, win_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [N-1:0]      ack_q, ack_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  qbar_q, qbar_d;
    logic              busy_q, busy_d;

    logic [WIDTH-1:0]  data_a [N];
    logic [PW-1:0]     cand;
    logic              found;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            data_a[i] = data[i*int'(WIDTH) +: WIDTH];
        end
    end

    // State register; clr wins over any transaction in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= RST_VAL;
            qbar_q  <= ~RST_VAL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        q_d     = q_q;
        qbar_d  = qbar_q;
        busy_d  = busy_q;
        found   = 1'b0;
        cand    = '0;

        case (state_q)
            S_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                // Search starts at ptr so the last winner goes to the back of the line.
                for (int k = 0; k < int'(N); k++) begin
                    cand = PW'((int'(ptr_q) + k) % int'(N));
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        win_d = cand;
                    end
                end
                if (found) begin
                    gnt_d   = N'(1) << win_d;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                q_d     = data_a[win_q];
                qbar_d  = ~data_a[win_q];
                ack_d   = N'(1) << win_q;
                state_d = S_ACK;
            end
            S_ACK: begin
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign q    = q_q;
    assign qbar = qbar_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: transaction-level model checked every cycle,
// plus hand-computed literal expectations for the listed scenarios.
module tb_dff_bank_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] RST_VAL = 8'h00;

    logic                 clk = 1'b0;
    logic                 clr = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N*WIDTH-1:0]   data = '0;
    logic [N-1:0]         gnt;
    logic [N-1:0]         ack;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     qbar;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    dff_bank_arbiter #(.N(N), .WIDTH(WIDTH), .RST_VAL(RST_VAL)) dut (
        .clk  (clk),
        .clr  (clr),
        .req  (req),
        .data (data),
        .gnt  (gnt),
        .ack  (ack),
        .q    (q),
        .qbar (qbar),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Transaction model: a write in progress is "cycles since grant" (0 = none).
    int              m_age = 0;
    int              m_win = 0;
    int              m_ptr = 0;
    logic [WIDTH-1:0] m_q  = RST_VAL;
    bit              chk_en = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < int'(N); k++) begin
            if (r[(p + k) % int'(N)]) return (p + k) % int'(N);
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_age = 0; m_win = 0; m_ptr = 0; m_q = RST_VAL;
        end else if (m_age == 0) begin
            if (req != '0) begin
                m_win = rr_pick(req, m_ptr);
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_q   = data[m_win*int'(WIDTH) +: WIDTH];
            m_age = 2;
        end else begin
            m_ptr = (m_win + 1) % int'(N);
            m_age = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] eg, ea;
            eg = (m_age != 0) ? N'(1 << m_win) : '0;
            ea = (m_age == 2) ? N'(1 << m_win) : '0;
            n_tests++;
            if (gnt !== eg || ack !== ea || q !== m_q || qbar !== ~m_q || busy !== (m_age != 0)) begin
                n_fail++;
                $display("FAIL model t=%0t gnt=%b/%b ack=%b/%b q=%h/%h qbar=%h/%h busy=%b/%b",
                         $time, gnt, eg, ack, ea, q, m_q, qbar, ~m_q, busy, (m_age != 0));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        data[i*int'(WIDTH) +: WIDTH] = v;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    int ack_cnt [N];
    int order [$];
    int exp_order [5];

    initial begin
        // 1: reset
        clr = 1'b1;
        step(); step();
        check("rst_q", 32'(q), 32'h00);
        check("rst_qbar", 32'(qbar), 32'hFF);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        clr = 1'b0;
        chk_en = 1'b1;

        // 2: single request from requester 2
        req = 4'b0100; set_data(2, 8'hA5);
        step();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_q_before", 32'(q), 32'h00);
        step();
        check("t2_q", 32'(q), 32'hA5);
        check("t2_ack", 32'(ack), 32'h4);
        req = '0;
        step();
        check("t2_ack_gone", 32'(ack), 32'h0);
        check("t2_gnt_gone", 32'(gnt), 32'h0);

        // 3: all four requesting, round order from ptr=0
        do_clr();
        for (int i = 0; i < int'(N); i++) begin
            set_data(i, 8'h10 + WIDTH'(i));
            ack_cnt[i] = 0;
        end
        req = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            step();
            for (int i = 0; i < int'(N); i++) begin
                if (ack[i]) begin
                    order.push_back(i);
                    if (order.size() <= 4) ack_cnt[i]++;
                    check("t3_q_owner", 32'(q), 32'(8'h10 + WIDTH'(i)));
                end
            end
        end
        req = '0;
        exp_order = '{0, 1, 2, 3, 0};
        check("t3_n_acks", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("t3_order", (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));
        end
        for (int i = 0; i < int'(N); i++) check("t3_once", 32'(ack_cnt[i]), 32'd1);
        step(); step();

        // 4: ptr wrap 3->0, then requester 0 alone
        do_clr();
        req = 4'b0100; set_data(2, 8'h22);
        step(); step(); req = '0; step();
        req = 4'b1000; set_data(3, 8'h33);
        step(); step(); req = '0; step();
        req = 4'b1001; set_data(0, 8'h44);
        step();
        check("t4_wrap_gnt", 32'(gnt), 32'h1);
        step(); step();
        req = 4'b0001;
        ack_cnt[0] = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (ack == 4'b0001) ack_cnt[0]++;
        end
        check("t4_solo_acks", 32'(ack_cnt[0]), 32'd3);
        req = '0;
        step(); step(); step();

        // 5: requester 1 drops req during LOAD
        do_clr();
        req = 4'b0010; set_data(1, 8'h3C);
        step();
        check("t5_gnt", 32'(gnt), 32'h2);
        req = '0;
        step();
        check("t5_q", 32'(q), 32'h3C);
        check("t5_ack", 32'(ack), 32'h2);
        step();

        // 6: clr during LOAD aborts; next arbitration from ptr=0
        req = 4'b0010; set_data(1, 8'h5A);
        step(); step(); req = '0; step();
        req = 4'b1000; set_data(3, 8'h77);
        step();
        check("t6_gnt", 32'(gnt), 32'h8);
        req = '0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t6_q", 32'(q), 32'h00);
        check("t6_ack", 32'(ack), 32'h0);
        check("t6_gnt_clr", 32'(gnt), 32'h0);
        req = 4'b1111;
        for (int i = 0; i < int'(N); i++) set_data(i, 8'hC0 + WIDTH'(i));
        step();
        check("t6_ptr0", 32'(gnt), 32'h1);
        step();
        check("t6_q_new", 32'(q), 32'hC0);
        req = '0;
        step(); step();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
